// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator.
// Holds the default fetch window (reset address and last legal word of the
// 1024-word instruction memory), the next-PC select encoding and the
// three-state FSM encoding used by pc_gen.
package pc_gen_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_LAST_DEF  = 32'h0000_3FFC;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_REG    = 2'b11
    } npc_sel_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } pc_state_e;

endpackage

// File: rtl/pc_gen_npc.sv
// npc_calc: combinational next-PC candidate selection and legality check.
// Ports:
//   pc       in  32  current fetch address
//   npc_sel  in   2  00 PC+4, 01 branch, 10 jump, 11 register
//   imm16    in  16  signed branch offset in words
//   target26 in  26  jump instruction index
//   rs_val   in  32  register jump target
//   npc      out 32  selected candidate
//   legal    out  1  candidate is word aligned and inside [PC_RESET, IM_LAST]
module npc_calc
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] IM_LAST  = IM_LAST_DEF
) (
    input  logic [31:0] pc,
    input  logic [1:0]  npc_sel,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] rs_val,
    output logic [31:0] npc,
    output logic        legal
);

    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    npc_sel_e    sel;

    assign pc_plus4   = pc + 32'd4;
    // Word offset sign-extended and scaled to bytes; the add wraps mod 2^32.
    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};
    assign sel        = npc_sel_e'(npc_sel);

    always_comb begin
        npc = pc_plus4;
        case (sel)
            NPC_SEQ:    npc = pc_plus4;
            NPC_BRANCH: npc = pc_plus4 + branch_off;
            NPC_JUMP:   npc = {pc_plus4[31:28], target26, 2'b00};
            NPC_REG:    npc = rs_val;
            default:    npc = pc_plus4;
        endcase
    end

    assign legal = (npc[1:0] == 2'b00) && (npc >= PC_RESET) && (npc <= IM_LAST);

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter register with a RUN/HALT/FAULT state machine.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   en              advance enable (0 = stall, everything holds)
//   npc_sel         next-PC select, see pc_gen_pkg::npc_sel_e
//   imm16/target26/rs_val  next-PC operands
//   halt_req        stop fetching (wins over a fault)
//   pc              current fetch address
//   pc_plus8        link value, pc+8 combinationally
//   running/fault   state decodes
//   fault_addr      illegal candidate captured on fault entry
//   fetch_cnt       number of PC advances since reset (wraps)
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] IM_LAST  = IM_LAST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  npc_sel,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] rs_val,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic        running,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_cnt
);

    pc_state_e   state, state_next;
    logic [31:0] pc_next, cnt_next, fault_addr_next;
    logic [31:0] npc;
    logic        legal;

    npc_calc #(
        .PC_RESET (PC_RESET),
        .IM_LAST  (IM_LAST)
    ) u_npc_calc (
        .pc       (pc),
        .npc_sel  (npc_sel),
        .imm16    (imm16),
        .target26 (target26),
        .rs_val   (rs_val),
        .npc      (npc),
        .legal    (legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            pc         <= PC_RESET;
            fetch_cnt  <= 32'd0;
            fault_addr <= 32'd0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            fetch_cnt  <= cnt_next;
            fault_addr <= fault_addr_next;
        end
    end

    // HALT and FAULT are terminal, so only RUN with en=1 can change anything.
    // halt_req is tested before legality so a halt masks a simultaneous fault.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        cnt_next        = fetch_cnt;
        fault_addr_next = fault_addr;
        if (state == ST_RUN && en) begin
            if (halt_req) begin
                state_next = ST_HALT;
            end else if (legal) begin
                pc_next  = npc;
                cnt_next = fetch_cnt + 32'd1;
            end else begin
                state_next      = ST_FAULT;
                fault_addr_next = npc;
            end
        end
    end

    assign pc_plus8 = pc + 32'd8;
    assign running  = (state == ST_RUN);
    assign fault    = (state == ST_FAULT);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes hand-computed expectations
// into a queue after each clock edge (or reset pulse), and a monitor on the
// falling edge pops and compares them against the DUT outputs.
module tb_pc_gen;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        running;
        logic        fault;
        logic [31:0] fault_addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  npc_sel;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] rs_val;
    logic        halt_req;
    logic [31:0] pc, pc_plus8, fault_addr, fetch_cnt;
    logic        running, fault;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pc_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .npc_sel    (npc_sel),
        .imm16      (imm16),
        .target26   (target26),
        .rs_val     (rs_val),
        .halt_req   (halt_req),
        .pc         (pc),
        .pc_plus8   (pc_plus8),
        .running    (running),
        .fault      (fault),
        .fault_addr (fault_addr),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp({e.tag, ".pc"}, pc, e.pc);
        cmp({e.tag, ".pc_plus8"}, pc_plus8, e.pc + 32'd8);
        cmp({e.tag, ".fetch_cnt"}, fetch_cnt, e.cnt);
        cmp({e.tag, ".running"}, {31'd0, running}, {31'd0, e.running});
        cmp({e.tag, ".fault"}, {31'd0, fault}, {31'd0, e.fault});
        cmp({e.tag, ".fault_addr"}, fault_addr, e.fault_addr);
    endtask

    function automatic exp_t mk(input string tag, input logic [31:0] p, input logic [31:0] c,
                                input logic r, input logic f, input logic [31:0] fa);
        exp_t e;
        e.tag = tag; e.pc = p; e.cnt = c; e.running = r; e.fault = f; e.fault_addr = fa;
        return e;
    endfunction

    // Drive one cycle of inputs, let the edge happen, then record the expectation.
    task automatic applyStimulus(input string tag, input logic e_n, input logic [1:0] sel,
                                 input logic [15:0] imm, input logic [25:0] tgt,
                                 input logic [31:0] rs, input logic halt, input exp_t e);
        en = e_n; npc_sel = sel; imm16 = imm; target26 = tgt; rs_val = rs; halt_req = halt;
        @(posedge clk);
        #1;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Reset pulse fully between two rising edges; checked while still low.
    task automatic pulseReset(input string tag);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 exp_q.push_back(mk(tag, 32'h3000, 0, 1'b1, 1'b0, 0));
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compares whatever expectation is pending at each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; npc_sel = 2'b00; imm16 = '0; target26 = '0;
        rs_val = '0; halt_req = 1'b0;
        @(posedge clk);
        #1 exp_q.push_back(mk("por", 32'h3000, 0, 1'b1, 1'b0, 0));
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Sequential fetch
        applyStimulus("seq1", 1, 2'b00, 16'h0, 26'h0, 32'h0, 0, mk("", 32'h3004, 1, 1, 0, 0));
        applyStimulus("seq2", 1, 2'b00, 16'h0, 26'h0, 32'h0, 0, mk("", 32'h3008, 2, 1, 0, 0));
        applyStimulus("seq3", 1, 2'b00, 16'h0, 26'h0, 32'h0, 0, mk("", 32'h300C, 3, 1, 0, 0));
        applyStimulus("seq4", 1, 2'b00, 16'h0, 26'h0, 32'h0, 0, mk("", 32'h3010, 4, 1, 0, 0));
        // Backward branch, then a forward branch out of range
        applyStimulus("br_back", 1, 2'b01, 16'hFFFC, 26'h0, 32'h0, 0, mk("", 32'h3004, 5, 1, 0, 0));
        applyStimulus("br_far", 1, 2'b01, 16'h7FFF, 26'h0, 32'h0, 0, mk("", 32'h3004, 5, 0, 1, 32'h0002_3004));
        applyStimulus("flt_hold", 1, 2'b00, 16'h0, 26'h0, 32'h0, 0, mk("", 32'h3004, 5, 0, 1, 32'h0002_3004));
        pulseReset("rst_fault");

        // Jump then misaligned register target
        applyStimulus("j_seq1", 1, 2'b00, 16'h0, 26'h0, 32'h0, 0, mk("", 32'h3004, 1, 1, 0, 0));
        applyStimulus("j_seq2", 1, 2'b00, 16'h0, 26'h0, 32'h0, 0, mk("", 32'h3008, 2, 1, 0, 0));
        applyStimulus("jump", 1, 2'b10, 16'h0, 26'h0000C40, 32'h0, 0, mk("", 32'h3100, 3, 1, 0, 0));
        applyStimulus("jr_mis", 1, 2'b11, 16'h0, 26'h0, 32'h3102, 0, mk("", 32'h3100, 3, 0, 1, 32'h3102));
        pulseReset("rst_fault2");

        // Stall holds everything, then upper boundary legal, one past illegal
        applyStimulus("s_seq", 1, 2'b00, 16'h0, 26'h0, 32'h0, 0, mk("", 32'h3004, 1, 1, 0, 0));
        for (int i = 0; i < 5; i++)
            applyStimulus("stall", 0, 2'b11, 16'h0, 26'h0, 32'h3FFC, 1, mk("", 32'h3004, 1, 1, 0, 0));
        applyStimulus("jr_last", 1, 2'b11, 16'h0, 26'h0, 32'h3FFC, 0, mk("", 32'h3FFC, 2, 1, 0, 0));
        applyStimulus("past_end", 1, 2'b00, 16'h0, 26'h0, 32'h0, 0, mk("", 32'h3FFC, 2, 0, 1, 32'h4000));
        pulseReset("rst_fault3");

        // Lower boundary legal, halt masking an illegal candidate, terminal HALT
        applyStimulus("jr_first", 1, 2'b11, 16'h0, 26'h0, 32'h3000, 0, mk("", 32'h3000, 1, 1, 0, 0));
        applyStimulus("halt", 1, 2'b11, 16'h0, 26'h0, 32'hFFFF_0001, 1, mk("", 32'h3000, 1, 0, 0, 0));
        applyStimulus("halt_hold", 1, 2'b00, 16'h0, 26'h0, 32'h0, 0, mk("", 32'h3000, 1, 0, 0, 0));
        pulseReset("rst_halt");
        applyStimulus("below", 1, 2'b11, 16'h0, 26'h0, 32'h2FFC, 0, mk("", 32'h3000, 0, 0, 1, 32'h2FFC));

        // Mid-stall reset
        pulseReset("rst_fault4");
        applyStimulus("m_seq", 1, 2'b00, 16'h0, 26'h0, 32'h0, 0, mk("", 32'h3004, 1, 1, 0, 0));
        en = 1'b0;
        pulseReset("rst_stall");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
